pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 37 +++
 rtl/pc_gen_bht.sv | 54 +++++
 rtl/pc_gen.sv | 95 +++++++++
 tb/tb_pc_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Brief    : Shared constants and types for the PC generator and its branch
//            history table (instruction size, 2-bit counter encodings).
// Revision : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    // Bytes per instruction; sequential fetch advances by this amount.
    localparam int unsigned C_INST_BYTES = 4;

    // 2-bit saturating direction counter; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } bht_cnt_e;

    // Every history entry starts weakly not-taken.
    localparam bht_cnt_e C_BHT_RESET = CNT_WNT;

    // Saturating increment on taken, decrement on not-taken.
    function automatic logic [1:0] bht_cnt_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != CNT_ST) nxt = cur + 2'd1;
        end else begin
            if (cur != CNT_SNT) nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_bht.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_bht
// Brief    : Branch history table of 2-bit saturating counters, indexed by
//            word address. Combinational lookup port, registered update port,
//            asynchronous active-low reset to weakly not-taken.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen_bht
    import pc_gen_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned BHT_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_lkp_pc,
    output logic              o_lkp_taken,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_cnt [BHT_DEPTH];
    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_upd_next;
    logic             w_unused_bits;

    // Byte offset bits and bits above the index do not select an entry.
    assign w_lkp_idx     = i_lkp_pc[IDX_W+1:2];
    assign w_upd_idx     = i_upd_pc[IDX_W+1:2];
    assign w_unused_bits = ^{i_lkp_pc[ADDR_W-1:IDX_W+2], i_lkp_pc[1:0],
                             i_upd_pc[ADDR_W-1:IDX_W+2], i_upd_pc[1:0]};

    // Lookup reads the stored value, so a same-cycle update is not visible yet.
    assign o_lkp_taken = r_cnt[w_lkp_idx][1];
    assign w_upd_next  = bht_cnt_next(r_cnt[w_upd_idx], i_upd_taken);

    // Counter storage: async clear to weakly not-taken, one entry updated per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_DEPTH); i++) begin
                r_cnt[i] <= C_BHT_RESET;
            end
        end else if (i_upd_valid) begin
            r_cnt[w_upd_idx] <= w_upd_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch PC generator. Registered next-PC selection with priority
//            execute redirect > predicted-taken decode branch > sequential
//            advance > hold. Global enable freezes the PC and masks validity.
//            Build macro PC_GEN_BHT_EN: when defined, direction prediction
//            comes from a 2-bit counter BHT (pc_gen_bht); when undefined,
//            prediction is static backward-taken and exu_upd_* are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       BHT_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              if_ready,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              idu_bran_valid,
    input  logic [ADDR_W-1:0] idu_inst_pc,
    input  logic [ADDR_W-1:0] idu_imm,
    output logic              idu_pred_taken,
    input  logic              exu_redirect,
    input  logic [ADDR_W-1:0] exu_redirect_pc,
    input  logic              exu_upd_valid,
    input  logic [ADDR_W-1:0] exu_upd_pc,
    input  logic              exu_upd_taken
);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_dir_taken;

    // Validity is masked immediately by ena and re-arms one edge after ena returns.
    assign pc             = r_pc;
    assign pc_valid       = r_pc_valid & ena;
    assign idu_pred_taken = idu_bran_valid & w_dir_taken;

`ifdef PC_GEN_BHT_EN
    pc_gen_bht #(
        .ADDR_W    (ADDR_W),
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_lkp_pc    (idu_inst_pc),
        .o_lkp_taken (w_dir_taken),
        .i_upd_valid (exu_upd_valid),
        .i_upd_pc    (exu_upd_pc),
        .i_upd_taken (exu_upd_taken)
    );
`else
    logic        w_unused_upd;
    logic [31:0] w_unused_cfg;

    // Static rule: a negative offset is a backward branch, predicted taken.
    assign w_dir_taken  = idu_imm[ADDR_W-1];
    assign w_unused_upd = ^{exu_upd_valid, exu_upd_taken, exu_upd_pc};
    assign w_unused_cfg = 32'(BHT_DEPTH);
`endif

    // Next-PC selection; arithmetic wraps naturally at ADDR_W bits.
    always_comb begin
        w_pc_next = r_pc;
        if (ena) begin
            if (exu_redirect) begin
                w_pc_next = exu_redirect_pc;
            end else if (idu_pred_taken) begin
                w_pc_next = idu_inst_pc + idu_imm;
            end else if (pc_valid && if_ready) begin
                w_pc_next = r_pc + ADDR_W'(C_INST_BYTES);
            end
        end
    end

    // PC and validity registers; async reset drops any in-flight redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pc_valid <= ena;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Self-checking bench for pc_gen. A behavioural model tracks the
//            expected fetch PC, validity and direction prediction every cycle;
//            directed vectors add literal expectations. Honours PC_GEN_BHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned BHT_DEPTH = 16;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        if_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic        idu_bran_valid;
    logic [31:0] idu_inst_pc;
    logic [31:0] idu_imm;
    logic        idu_pred_taken;
    logic        exu_redirect;
    logic [31:0] exu_redirect_pc;
    logic        exu_upd_valid;
    logic [31:0] exu_upd_pc;
    logic        exu_upd_taken;

    int n_chk = 0;
    int n_err = 0;
    bit checking = 1'b0;

    pc_gen #(
        .ADDR_W    (ADDR_W),
        .BHT_DEPTH (BHT_DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .if_ready        (if_ready),
        .pc_valid        (pc_valid),
        .pc              (pc),
        .idu_bran_valid  (idu_bran_valid),
        .idu_inst_pc     (idu_inst_pc),
        .idu_imm         (idu_imm),
        .idu_pred_taken  (idu_pred_taken),
        .exu_redirect    (exu_redirect),
        .exu_redirect_pc (exu_redirect_pc),
        .exu_upd_valid   (exu_upd_valid),
        .exu_upd_pc      (exu_upd_pc),
        .exu_upd_taken   (exu_upd_taken)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    bit          m_armed;
    int          m_bht [BHT_DEPTH];

    function automatic int bht_index(input logic [31:0] a);
        return int'((a / 4) % BHT_DEPTH);
    endfunction

    function automatic bit model_pred();
        if (!idu_bran_valid) return 1'b0;
`ifdef PC_GEN_BHT_EN
        return m_bht[bht_index(idu_inst_pc)] >= 2;
`else
        return idu_imm[31];
`endif
    endfunction

    function automatic bit model_valid();
        return m_armed && ena;
    endfunction

    function automatic logic [31:0] model_next_pc();
        if (!ena)               return m_pc;
        if (exu_redirect)       return exu_redirect_pc;
        if (model_pred())       return idu_inst_pc + idu_imm;
        if (model_valid() && if_ready) return m_pc + 32'd4;
        return m_pc;
    endfunction

    function automatic int model_cnt_next(input int cur, input bit taken);
        if (taken) return (cur == 3) ? 3 : cur + 1;
        return (cur == 0) ? 0 : cur - 1;
    endfunction

    // Model state advance on each edge, async reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= RESET_PC;
            m_armed <= 1'b0;
            for (int i = 0; i < int'(BHT_DEPTH); i++) m_bht[i] <= 1;
        end else begin
            m_pc    <= model_next_pc();
            m_armed <= ena;
`ifdef PC_GEN_BHT_EN
            if (exu_upd_valid)
                m_bht[bht_index(exu_upd_pc)] <= model_cnt_next(m_bht[bht_index(exu_upd_pc)], exu_upd_taken);
`endif
        end
    end

    // Every-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        if (checking) begin
            n_chk = n_chk + 1;
            if (pc !== m_pc) begin
                n_err = n_err + 1;
                $display("FAIL cmp_pc t=%0t actual=%h required=%h", $time, pc, m_pc);
            end
            n_chk = n_chk + 1;
            if (pc_valid !== model_valid()) begin
                n_err = n_err + 1;
                $display("FAIL cmp_pc_valid t=%0t actual=%b required=%b", $time, pc_valid, model_valid());
            end
            n_chk = n_chk + 1;
            if (idu_pred_taken !== model_pred()) begin
                n_err = n_err + 1;
                $display("FAIL cmp_pred t=%0t actual=%b required=%b", $time, idu_pred_taken, model_pred());
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        idu_bran_valid  = 1'b0;
        idu_inst_pc     = 32'h0;
        idu_imm         = 32'h0;
        exu_redirect    = 1'b0;
        exu_redirect_pc = 32'h0;
        exu_upd_valid   = 1'b0;
        exu_upd_pc      = 32'h0;
        exu_upd_taken   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        if_ready = 1'b1;
        clear_side();

        // Reset state
        step();
        checking = 1'b1;
        step();
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'd0, pc_valid}, 32'd0);

        // Release with ena=1, if_ready=1: 0x0, 0x4, 0x8
        rst_n = 1'b1;
        step();
        chk("boot_pc0", pc, 32'h0);
        chk("boot_valid0", {31'd0, pc_valid}, 32'd1);
        step();
        chk("boot_pc1", pc, 32'h4);
        step();
        chk("boot_pc2", pc, 32'h8);

`ifdef PC_GEN_BHT_EN
        // Counter training on 0x40
        if_ready       = 1'b0;
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h40;
        idu_imm        = 32'h20;
        #1 chk("bht_reset_pred", {31'd0, idu_pred_taken}, 32'd0);
        idu_bran_valid = 1'b0;
        exu_upd_valid  = 1'b1;
        exu_upd_pc     = 32'h40;
        exu_upd_taken  = 1'b1;
        repeat (3) step();
        exu_upd_valid  = 1'b0;
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h40;
        idu_imm        = 32'h20;
        #1 chk("bht_trained_pred", {31'd0, idu_pred_taken}, 32'd1);
        step();
        chk("bht_branch_pc", pc, 32'h60);
        clear_side();

        // Same-cycle lookup and update on 0x44 sees the old value
        exu_upd_valid  = 1'b1;
        exu_upd_pc     = 32'h44;
        exu_upd_taken  = 1'b1;
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h44;
        idu_imm        = 32'h8;
        #1 chk("bht_bypass_old", {31'd0, idu_pred_taken}, 32'd0);
        step();
        exu_upd_valid = 1'b0;
        #1 chk("bht_after_upd", {31'd0, idu_pred_taken}, 32'd1);
        idu_bran_valid = 1'b0;
        step();
        // Saturate low: 4 not-taken, then one taken -> 1
        exu_upd_valid = 1'b1;
        exu_upd_taken = 1'b0;
        repeat (4) step();
        exu_upd_taken = 1'b1;
        step();
        exu_upd_valid  = 1'b0;
        idu_bran_valid = 1'b1;
        #1 chk("bht_sat_low", {31'd0, idu_pred_taken}, 32'd0);
        clear_side();
        if_ready = 1'b1;
`endif

        // Execute redirect beats a same-cycle predicted-taken decode branch
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h100;
        step();
        exu_redirect = 1'b0;
        chk("redir_pc", pc, 32'h100);
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h2000;
        idu_bran_valid  = 1'b1;
        idu_inst_pc     = 32'h40;
        idu_imm         = 32'hFFFF_FFF0;
        #1 chk("prio_pred", {31'd0, idu_pred_taken}, 32'd1);
        step();
        chk("prio_exu_wins", pc, 32'h2000);
        clear_side();
        idu_imm = 32'hFFFF_FFF0;
        #1 chk("pred_gated", {31'd0, idu_pred_taken}, 32'd0);
        clear_side();

        // Back-pressure hold, then ena=0
        step();
        chk("seq_pc", pc, 32'h2004);
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_pc", pc, 32'h2004);
        end
        ena = 1'b0;
        #1 chk("ena0_valid", {31'd0, pc_valid}, 32'd0);
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h5000;
`ifdef PC_GEN_BHT_EN
        exu_upd_valid = 1'b1;
        exu_upd_pc    = 32'h48;
        exu_upd_taken = 1'b1;
`endif
        step();
        step();
        chk("ena0_redir_ignored", pc, 32'h2004);
        chk("ena0_valid2", {31'd0, pc_valid}, 32'd0);
        clear_side();
`ifdef PC_GEN_BHT_EN
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h48;
        #1 chk("ena0_upd_applied", {31'd0, idu_pred_taken}, 32'd1);
        clear_side();
`endif
        ena = 1'b1;
        step();
        chk("ena1_valid", {31'd0, pc_valid}, 32'd1);
        chk("ena1_pc", pc, 32'h2004);

        // Wrap at top of address space
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'hFFFF_FFFC;
        step();
        exu_redirect = 1'b0;
        if_ready     = 1'b1;
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_zero", pc, 32'h0);
        step();
        chk("wrap_after", pc, 32'h4);

`ifndef PC_GEN_BHT_EN
        // Static backward-taken prediction
        if_ready       = 1'b0;
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h80;
        idu_imm        = 32'hFFFF_FFF0;
        #1 chk("static_back_pred", {31'd0, idu_pred_taken}, 32'd1);
        step();
        chk("static_back_pc", pc, 32'h70);
        idu_imm = 32'h10;
        #1 chk("static_fwd_pred", {31'd0, idu_pred_taken}, 32'd0);
        step();
        chk("static_fwd_pc", pc, 32'h70);
        clear_side();
`endif

        // Reset mid-operation drops a pending redirect
        if_ready        = 1'b1;
        exu_redirect    = 1'b1;
        exu_redirect_pc = 32'h3000;
        #2 rst_n = 1'b0;
        #1 chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'd0, pc_valid}, 32'd0);
        step();
        clear_side();
        rst_n = 1'b1;
        chk("midrst_held", pc, 32'h0);
        step();
        chk("midrst_rel_pc", pc, 32'h0);
        chk("midrst_rel_valid", {31'd0, pc_valid}, 32'd1);
`ifdef PC_GEN_BHT_EN
        idu_bran_valid = 1'b1;
        idu_inst_pc    = 32'h40;
        #1 chk("midrst_bht_clear", {31'd0, idu_pred_taken}, 32'd0);
        clear_side();
`endif
        step();
        chk("midrst_seq", pc, 32'h4);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
